// File: rtl/sc_alu_pkg.sv
// sc_alu_pkg: shared constants for the sequential ALU stage.
//   - opcode values ALU_ADD .. ALU_SRA (13-15 are reserved)
//   - FSM state encoding
//   - bit positions of N, Z, V, C inside the 4-bit status word
//   - is_shift(): true for the three shift opcodes
package sc_alu_pkg;

    typedef logic [3:0] op_t;

    localparam op_t ALU_ADD   = 4'd0;
    localparam op_t ALU_ADDCC = 4'd1;
    localparam op_t ALU_SUB   = 4'd2;
    localparam op_t ALU_SUBCC = 4'd3;
    localparam op_t ALU_AND   = 4'd4;
    localparam op_t ALU_OR    = 4'd5;
    localparam op_t ALU_XOR   = 4'd6;
    localparam op_t ALU_ANDCC = 4'd7;
    localparam op_t ALU_PASSA = 4'd8;
    localparam op_t ALU_PASSB = 4'd9;
    localparam op_t ALU_SLL   = 4'd10;
    localparam op_t ALU_SRL   = 4'd11;
    localparam op_t ALU_SRA   = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Status word layout is {N, Z, V, C}.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    function automatic logic is_shift(input op_t op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/sc_alu_seq_if.sv
// sc_alu_seq_if: request/status bundle between the register bank side and
// the sequential ALU.
//   SC_ALU_DataBUS_A_In / _B_In : operands (B[4:0] is the shift amount)
//   SC_ALU_Selection_In         : opcode
//   SC_ALU_Start_In             : request, sampled only while idle
//   SC_ALU_ENABLE_BUS_C         : drive result onto Bus C
//   SC_ALU_Flags_Out            : {N,Z,V,C}
//   SC_ALU_Busy_Out / _Done_Out : status
// master = requester side, slave = the ALU.
interface sc_alu_seq_if #(
    parameter int DATAWIDTH_BUS          = 32,
    parameter int DATAWIDTH_ALUSELECTION = 4
);
    import sc_alu_pkg::*;

    logic [DATAWIDTH_BUS-1:0]          SC_ALU_DataBUS_A_In;
    logic [DATAWIDTH_BUS-1:0]          SC_ALU_DataBUS_B_In;
    logic [DATAWIDTH_ALUSELECTION-1:0] SC_ALU_Selection_In;
    logic                              SC_ALU_Start_In;
    logic                              SC_ALU_ENABLE_BUS_C;
    logic [3:0]                        SC_ALU_Flags_Out;
    logic                              SC_ALU_Busy_Out;
    logic                              SC_ALU_Done_Out;

    modport master (
        output SC_ALU_DataBUS_A_In, SC_ALU_DataBUS_B_In, SC_ALU_Selection_In,
               SC_ALU_Start_In, SC_ALU_ENABLE_BUS_C,
        input  SC_ALU_Flags_Out, SC_ALU_Busy_Out, SC_ALU_Done_Out
    );

    modport slave (
        input  SC_ALU_DataBUS_A_In, SC_ALU_DataBUS_B_In, SC_ALU_Selection_In,
               SC_ALU_Start_In, SC_ALU_ENABLE_BUS_C,
        output SC_ALU_Flags_Out, SC_ALU_Busy_Out, SC_ALU_Done_Out
    );

endinterface

// File: rtl/sc_alu_core.sv
// sc_alu_core: purely combinational result and NZVC generation for the
// non-shift opcodes. Shift and reserved opcodes yield result 0 with
// flag_we low; the sequencer handles shifts itself.
//   a, b    : operands
//   op      : opcode
//   result  : operation result
//   nzvc    : candidate status word {N,Z,V,C}
//   flag_we : high for the flag-setting opcodes (ADDCC, SUBCC, ANDCC)
module sc_alu_core
    import sc_alu_pkg::*;
#(
    parameter int W  = 32,
    parameter int SW = 4
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [SW-1:0] op,
    output logic [W-1:0]  result,
    output logic [3:0]    nzvc,
    output logic          flag_we
);

    logic [W:0] sum;
    logic [W:0] diff;
    logic       v_add;
    logic       v_sub;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        // diff[W] is the borrow: set exactly when a < b unsigned.
        diff  = {1'b0, a} - {1'b0, b};
        v_add = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
        v_sub = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);

        result  = '0;
        nzvc    = '0;
        flag_we = 1'b0;

        case (op)
            ALU_ADD, ALU_ADDCC: begin
                result       = sum[W-1:0];
                nzvc[FLAG_V] = v_add;
                nzvc[FLAG_C] = sum[W];
                flag_we      = (op == ALU_ADDCC);
            end
            ALU_SUB, ALU_SUBCC: begin
                result       = diff[W-1:0];
                nzvc[FLAG_V] = v_sub;
                nzvc[FLAG_C] = diff[W];
                flag_we      = (op == ALU_SUBCC);
            end
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_ANDCC: begin
                result  = a & b;
                flag_we = 1'b1;
            end
            ALU_PASSA: result = a;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase

        nzvc[FLAG_N] = result[W-1];
        nzvc[FLAG_Z] = (result == '0);
    end

endmodule

// File: rtl/sc_alu_seq.sv
// sc_alu_seq: sequential ALU stage. Samples operands at the accepting
// edge, registers the result (driven tri-state onto Bus C) and keeps an
// NZVC status register. Shifts run one bit per clock through the SHIFT
// state unless SC_ALU_BARREL_SHIFT_EN is defined, in which case they are
// finished combinationally in one cycle (results are identical).
// Ports:
//   SC_ALU_CLOCK_50      : clock, rising edge
//   SC_ALU_Reset_InHigh  : synchronous active-high reset
//   bus (slave)          : operands, opcode, start, Bus C enable, flags,
//                          busy, done
//   SC_ALU_DataBUS_C_Out : result register, Z when Bus C is not enabled
// Bus C stays a plain port so the tri-state driver sits at the module
// boundary where it meets the shared bus.
module sc_alu_seq
    import sc_alu_pkg::*;
#(
    parameter int DATAWIDTH_BUS          = 32,
    parameter int DATAWIDTH_ALUSELECTION = 4,
    parameter int DATAWIDTH_SHAMT        = 5
) (
    input  logic                     SC_ALU_CLOCK_50,
    input  logic                     SC_ALU_Reset_InHigh,
    sc_alu_seq_if.slave              bus,
    output wire [DATAWIDTH_BUS-1:0]  SC_ALU_DataBUS_C_Out
);

    localparam int W = DATAWIDTH_BUS;

    logic [W-1:0]                 a;
    logic [W-1:0]                 b;
    logic [DATAWIDTH_SHAMT-1:0]   shamt;
    logic [DATAWIDTH_ALUSELECTION-1:0] sel;

    logic [W-1:0] core_result;
    logic [3:0]   core_nzvc;
    logic         core_we;

    state_t       state_q, state_d;
    logic [W-1:0] result_q, result_d;
    logic [3:0]   flags_q, flags_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
`ifndef SC_ALU_BARREL_SHIFT_EN
    logic [DATAWIDTH_SHAMT-1:0]        cnt_q, cnt_d;
    logic [DATAWIDTH_ALUSELECTION-1:0] op_q, op_d;
`endif

    assign a     = bus.SC_ALU_DataBUS_A_In;
    assign b     = bus.SC_ALU_DataBUS_B_In;
    assign sel   = bus.SC_ALU_Selection_In;
    assign shamt = b[DATAWIDTH_SHAMT-1:0];

    sc_alu_core #(
        .W  (W),
        .SW (DATAWIDTH_ALUSELECTION)
    ) u_core (
        .a       (a),
        .b       (b),
        .op      (sel),
        .result  (core_result),
        .nzvc    (core_nzvc),
        .flag_we (core_we)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifndef SC_ALU_BARREL_SHIFT_EN
        cnt_d    = cnt_q;
        op_d     = op_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.SC_ALU_Start_In) begin
                    if (is_shift(sel)) begin
`ifdef SC_ALU_BARREL_SHIFT_EN
                        case (sel)
                            ALU_SLL: result_d = a << shamt;
                            ALU_SRL: result_d = a >> shamt;
                            default: result_d = $unsigned($signed(a) >>> shamt);
                        endcase
                        state_d = ST_DONE;
`else
                        // Shift runs in place on the result register.
                        result_d = a;
                        cnt_d    = shamt;
                        op_d     = sel;
                        state_d  = (shamt == '0) ? ST_DONE : ST_SHIFT;
`endif
                    end else begin
                        result_d = core_result;
                        if (core_we) flags_d = core_nzvc;
                        state_d = ST_DONE;
                    end
                end
            end
`ifndef SC_ALU_BARREL_SHIFT_EN
            ST_SHIFT: begin
                case (op_q)
                    ALU_SLL: result_d = {result_q[W-2:0], 1'b0};
                    ALU_SRL: result_d = {1'b0, result_q[W-1:1]};
                    default: result_d = {result_q[W-1], result_q[W-1:1]};
                endcase
                cnt_d = cnt_q - 1'b1;
                // Last shift: counter is about to reach zero.
                if (cnt_q == {{(DATAWIDTH_SHAMT-1){1'b0}}, 1'b1}) state_d = ST_DONE;
            end
`endif
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Status outputs are registered views of the next state.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge SC_ALU_CLOCK_50) begin
        if (SC_ALU_Reset_InHigh) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifndef SC_ALU_BARREL_SHIFT_EN
            cnt_q    <= '0;
            op_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifndef SC_ALU_BARREL_SHIFT_EN
            cnt_q    <= cnt_d;
            op_q     <= op_d;
`endif
        end
    end

    assign bus.SC_ALU_Flags_Out = flags_q;
    assign bus.SC_ALU_Busy_Out  = busy_q;
    assign bus.SC_ALU_Done_Out  = done_q;

    assign SC_ALU_DataBUS_C_Out = bus.SC_ALU_ENABLE_BUS_C ? result_q : {W{1'bz}};

endmodule

// File: tb/tb_sc_alu_seq.sv
// Self-checking bench for sc_alu_seq: directed cases followed by random
// operations, each compared against a plain-arithmetic reference model.
module tb_sc_alu_seq;
    import sc_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    wire  [31:0] bus_c;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_result = '0;
    logic [3:0]  m_flags  = '0;

    sc_alu_seq_if #(.DATAWIDTH_BUS(32), .DATAWIDTH_ALUSELECTION(4)) bus ();

    sc_alu_seq #(
        .DATAWIDTH_BUS(32), .DATAWIDTH_ALUSELECTION(4), .DATAWIDTH_SHAMT(5)
    ) dut (
        .SC_ALU_CLOCK_50      (clk),
        .SC_ALU_Reset_InHigh  (rst),
        .bus                  (bus),
        .SC_ALU_DataBUS_C_Out (bus_c)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference model straight from the opcode table.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [3:0] fl, output logic [31:0] r, output int lat);
        longint sa, sb, sr, ua, ub;
        logic v, c;
        int sh;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
        sh = int'(b[4:0]);
        v = 1'b0; c = 1'b0; sr = 0; lat = 1; r = '0;
        case (op)
            4'd0, 4'd1: begin
                r = a + b; c = (ua + ub) > 64'd4294967295; sr = sa + sb;
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd2, 4'd3: begin
                r = a - b; c = (a < b); sr = sa - sb;
                v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd4, 4'd7: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd8: r = a;
            4'd9: r = b;
            4'd10: r = a << sh;
            4'd11: r = a >> sh;
            4'd12: r = $unsigned($signed(a) >>> sh);
            default: r = '0;
        endcase
`ifndef SC_ALU_BARREL_SHIFT_EN
        if (op >= 4'd10 && op <= 4'd12) lat = sh + 1;
`endif
        if (op == 4'd1 || op == 4'd3 || op == 4'd7)
            fl = {r[31], (r == 32'd0), v, c};
    endtask

    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        int lat, cyc;
        chk({tag, ".hold"}, bus_c, m_result);
        model(op, a, b, m_flags, er, lat);
        bus.SC_ALU_Selection_In = op;
        bus.SC_ALU_DataBUS_A_In = a;
        bus.SC_ALU_DataBUS_B_In = b;
        bus.SC_ALU_Start_In     = 1'b1;
        tick();
        bus.SC_ALU_Start_In     = 1'b0;
        bus.SC_ALU_DataBUS_A_In = $urandom;
        bus.SC_ALU_DataBUS_B_In = $urandom;
        cyc = 1;
        while (bus.SC_ALU_Done_Out !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, ".lat"}, cyc, lat);
        chk({tag, ".busy"}, {31'b0, bus.SC_ALU_Busy_Out}, 32'd1);
        chk({tag, ".res"}, bus_c, er);
        chk({tag, ".flags"}, {28'b0, bus.SC_ALU_Flags_Out}, {28'b0, m_flags});
        m_result = er;
        tick();
        chk({tag, ".done1"}, {30'b0, bus.SC_ALU_Busy_Out, bus.SC_ALU_Done_Out}, 32'd0);
    endtask

    initial begin
        int ones;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        bus.SC_ALU_Start_In     = 1'b0;
        bus.SC_ALU_Selection_In = '0;
        bus.SC_ALU_DataBUS_A_In = '0;
        bus.SC_ALU_DataBUS_B_In = '0;
        bus.SC_ALU_ENABLE_BUS_C = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst.busy", {31'b0, bus.SC_ALU_Busy_Out}, 32'd0);
        chk("rst.done", {31'b0, bus.SC_ALU_Done_Out}, 32'd0);
        chk("rst.flags", {28'b0, bus.SC_ALU_Flags_Out}, 32'd0);
        chk("rst.busc", bus_c, 32'd0);

        run_op("addcc", ALU_ADDCC, 32'hFFFF_FFFF, 32'd1);
        chk("addcc.nzvc", {28'b0, bus.SC_ALU_Flags_Out}, 32'b0101);
        run_op("add", ALU_ADD, 32'd1, 32'd1);
        chk("add.val", bus_c, 32'd2);
        run_op("subcc", ALU_SUBCC, 32'h8000_0000, 32'd1);
        chk("subcc.nzvc", {28'b0, bus.SC_ALU_Flags_Out}, 32'b0010);
        run_op("sra4", ALU_SRA, 32'h8000_0000, 32'hFFFF_FFE4);
        chk("sra4.val", bus_c, 32'hF800_0000);
        run_op("sll0", ALU_SLL, 32'h0000_1234, 32'd0);
        run_op("srl31", ALU_SRL, 32'hFFFF_FFFF, 32'h0000_001F);
        run_op("rsv", 4'd14, 32'h1234_5678, 32'h9ABC_DEF0);

        // Start pulses while busy are ignored; start held through DONE is
        // taken on the first idle cycle.
        bus.SC_ALU_Selection_In = ALU_SLL;
        bus.SC_ALU_DataBUS_A_In = 32'd1;
        bus.SC_ALU_DataBUS_B_In = 32'd3;
        bus.SC_ALU_Start_In     = 1'b1;
        tick();
        bus.SC_ALU_Selection_In = ALU_ADD;
        bus.SC_ALU_DataBUS_A_In = 32'd5;
        bus.SC_ALU_DataBUS_B_In = 32'd5;
        tick();
        bus.SC_ALU_Start_In = 1'b0;
        tick();
        bus.SC_ALU_Start_In = 1'b1;
        tick();
`ifndef SC_ALU_BARREL_SHIFT_EN
        chk("b2b.done", {31'b0, bus.SC_ALU_Done_Out}, 32'd1);
        chk("b2b.sll", bus_c, 32'd8);
        tick();
        chk("b2b.idle", {30'b0, bus.SC_ALU_Busy_Out, bus.SC_ALU_Done_Out}, 32'd0);
        tick();
        bus.SC_ALU_Start_In = 1'b0;
        chk("b2b.done2", {31'b0, bus.SC_ALU_Done_Out}, 32'd1);
        chk("b2b.add", bus_c, 32'd10);
        tick();
`else
        bus.SC_ALU_Start_In = 1'b0;
        tick();
        tick();
`endif
        m_result = 32'd10;

        bus.SC_ALU_ENABLE_BUS_C = 1'b0;
        #1;
        total++;
        assert (bus_c !== 32'd10) else begin
            bad++;
            $error("FAIL busc.off: got %h want high-Z", bus_c);
        end
        bus.SC_ALU_ENABLE_BUS_C = 1'b1;
        #1;
        chk("busc.on", bus_c, 32'd10);

        // Reset in the middle of a long shift discards it.
        bus.SC_ALU_Selection_In = ALU_SRL;
        bus.SC_ALU_DataBUS_A_In = 32'hDEAD_BEEF;
        bus.SC_ALU_DataBUS_B_In = 32'd20;
        bus.SC_ALU_Start_In     = 1'b1;
        tick();
        bus.SC_ALU_Start_In = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.busy", {31'b0, bus.SC_ALU_Busy_Out}, 32'd0);
        chk("midrst.done", {31'b0, bus.SC_ALU_Done_Out}, 32'd0);
        chk("midrst.res", bus_c, 32'd0);
        chk("midrst.flags", {28'b0, bus.SC_ALU_Flags_Out}, 32'd0);
        m_flags = '0;
        m_result = '0;
        ones = 0;
        repeat (30) begin
            tick();
            if (bus.SC_ALU_Done_Out === 1'b1) ones++;
        end
        chk("midrst.nodone", ones, 0);

        for (int i = 0; i < 30; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 5 == 0) ra = 32'h8000_0000 | ra;
            run_op($sformatf("rnd%0d", i), rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sc_alu_seq.md
Name: sc_alu_seq

Overview:
- Sequential ALU stage directly downstream of the datapath register bank.
- Consumes operands driven onto the shared tri-state Bus A and Bus B by the selected fixed and general registers.
- Computes the selected operation and holds the result in a result register that drives Bus C back toward register write-back.
- Maintains an NZVC status register; shifts are iterative, one bit per clock.

Parameters:
- DATAWIDTH_BUS, 32, operand/result bus width.
- DATAWIDTH_ALUSELECTION, 4, operation selector width.
- DATAWIDTH_SHAMT, 5, shift-amount width, taken from Bus B LSBs.

Ports:
- SC_ALU_CLOCK_50  input  1  system clock; all state changes on the rising edge.
- SC_ALU_Reset_InHigh  input  1  synchronous, active-high reset.
- SC_ALU_DataBUS_A_In  input  DATAWIDTH_BUS  operand A from Bus A.
- SC_ALU_DataBUS_B_In  input  DATAWIDTH_BUS  operand B from Bus B; bits [4:0] give the shift amount.
- SC_ALU_Selection_In  input  DATAWIDTH_ALUSELECTION  operation code.
- SC_ALU_Start_In  input  1  request; sampled only in IDLE.
- SC_ALU_ENABLE_BUS_C  input  1  drives the result onto Bus C when high, Z otherwise.
- SC_ALU_DataBUS_C_Out  output  DATAWIDTH_BUS  result register, tri-stated.
- SC_ALU_Flags_Out  output  4  {N,Z,V,C} status register.
- SC_ALU_Busy_Out  output  1  high whenever the state is not IDLE.
- SC_ALU_Done_Out  output  1  one-cycle pulse when the result is valid.

Behaviour:
- Reset (one clock, synchronous, active-high):
  - State goes to IDLE.
  - Result, flags, shift counter and latched opcode all clear to 0.
  - Busy=0, Done=0.
  - Bus C output is 0 if enabled, Z if not.
  - Reset overrides everything, including mid-shift; any partial result is discarded.
- Opcodes:
  - 0 ADD, 1 ADDCC, 2 SUB, 3 SUBCC, 4 AND, 5 OR, 6 XOR, 7 ANDCC, 8 PASSA, 9 PASSB.
  - 10 SLL, 11 SRL, 12 SRA.
  - 13-15 reserved: result=0, flags unchanged, 1-cycle latency.
- Arithmetic:
  - Modulo 2^DATAWIDTH_BUS.
  - C = carry out for ADD. For SUB, C = borrow, i.e. A<B unsigned.
  - V = signed overflow. N = result MSB. Z = (result==0).
  - Flags update only on opcodes 1, 3 and 7. ANDCC sets V=0 and C=0.
  - Shifts never change flags.
- State machine IDLE, SHIFT, DONE:
  - IDLE, Start=1, non-shift opcode: compute and register the result at that edge, then go to DONE.
  - IDLE, Start=1, shift opcode: load A into result, load B[4:0] into the counter, latch the opcode. Counter 0 goes to DONE; otherwise go to SHIFT.
  - SHIFT: each edge shifts the result by 1 (SRL fills 0, SRA replicates MSB, SLL fills 0) and decrements the counter. When the counter reaches 0, go to DONE.
  - DONE: Done=1 for exactly one cycle, then IDLE.
- Latency:
  - Non-shift and shift-by-0: Done one cycle after the Start edge.
  - Shift by n: Done n+1 cycles after the Start edge.
- Boundary conditions:
  - Start while Busy=1 (SHIFT or DONE) is ignored, not queued.
  - Operand buses are sampled only at the accepting edge; later bus changes or Z do not affect the operation.
  - Result holds its value until the next accepted Start.
  - Back-to-back requests: Start held high is re-accepted on the first IDLE cycle after DONE.
  - Shift amount uses B[4:0] only; upper bits are ignored. Shift by 31 takes 32 cycles.

Optional Feature:
- Macro SC_ALU_BARREL_SHIFT_EN.
- Defined: shifts are computed combinationally with a barrel shifter in IDLE and go straight to DONE. Every opcode has 1-cycle latency and the SHIFT state and counter are not instantiated.
- Undefined: iterative shift as described above.
- Results must be bit-identical in both builds.

Decomposition:
- Shared package sc_alu_pkg:
  - Opcode constants (ALU_ADD through ALU_SRA).
  - State encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Flag bit index constants.
- One sub-module, sc_alu_core: purely combinational result/NZVC computation for non-shift opcodes, reused by the FSM wrapper.

Test Plan:
- Reset mid-shift: SRL with B=20, assert reset at cycle 5 -> next cycle Busy=0, Done=0, result=0, flags=0; no Done pulse follows.
- ADDCC A=32'hFFFFFFFF, B=1 -> Done at cycle +1, result 0, flags N=0 Z=1 V=0 C=1. Then ADD A=1, B=1 -> result 2, flags unchanged.
- SUBCC A=32'h80000000, B=1 -> result 32'h7FFFFFFF, V=1, N=0, C=0, Z=0.
- SRA A=32'h80000000, B=32'hFFFFFFE4 (shamt 4) -> Busy for 5 cycles, Done at cycle +5, result 32'hF8000000, flags unchanged.
- Start pulses during an SLL by 3 (A=1) -> ignored, result 8. With Start held high, a new op is accepted on the first IDLE cycle.
- SC_ALU_ENABLE_BUS_C=0 -> Bus C all Z. Enable=1 -> result value. Shift-by-0 SLL A=32'h1234 -> result 32'h1234, Done at cycle +1.
